// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed seven-segment bus: samples each scanned digit,
// decodes it back to BCD and publishes a frame once two consecutive scans agree.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                    CLK100MHZ,
    input  logic                    RESET_BTN,
    input  logic [7:0]              SevenSegment,
    input  logic [7:0]              SegmentDrivers,
    output logic [4*NUM_DIGITS-1:0] DIGITS,
    output logic [NUM_DIGITS-1:0]   DP_OUT,
    output logic                    FRAME_VALID,
    output logic                    DIGIT_ERR,
    output logic                    SCAN_TIMEOUT,
    output logic [7:0]              GLITCH_CNT
);

    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       UPPER_MASK = 8'(8'hFF << NUM_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   seg_decode = 4'h0;
            7'h79:   seg_decode = 4'h1;
            7'h24:   seg_decode = 4'h2;
            7'h30:   seg_decode = 4'h3;
            7'h19:   seg_decode = 4'h4;
            7'h12:   seg_decode = 4'h5;
            7'h02:   seg_decode = 4'h6;
            7'h78:   seg_decode = 4'h7;
            7'h00:   seg_decode = 4'h8;
            7'h10:   seg_decode = 4'h9;
            7'h7F:   seg_decode = 4'hE;
            default: seg_decode = 4'hF;
        endcase
    endfunction

    logic [7:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [7:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    state_t           state_q, state_d;
    logic [7:0]       lat_an_q, lat_an_d, lat_seg_q, lat_seg_d;
    logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [DW-1:0]    shadow_q, shadow_d, prev_q, prev_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, prev_dp_q, prev_dp_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic             have_prev_q, have_prev_d;
    logic             done_q, done_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [DW-1:0]    digits_q, digits_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic             fv_q, fv_d, err_q, err_d, tout_q, tout_d;
    logic [7:0]       glitch_q, glitch_d;

    logic [7:0]       low_bits_c;
    logic             an_idle_c, an_legal_c, an_glitch_c;
    logic [IDX_W-1:0] an_idx_c;
    logic             do_sample_c;
    logic [3:0]       code_c;
    logic             frame_has_f_c;

    // Double-register the bus before any decision is made on it
    always_comb begin
        an_s1_d  = SegmentDrivers;
        an_s2_d  = an_s1_q;
        seg_s1_d = SevenSegment;
        seg_s2_d = seg_s1_q;
    end

    // Anode classification: idle gap, single selected digit, or glitch
    always_comb begin
        low_bits_c  = ~an_s2_q & ~UPPER_MASK;
        an_idle_c   = (an_s2_q == 8'hFF);
        an_legal_c  = ((an_s2_q & UPPER_MASK) == UPPER_MASK) && (low_bits_c != 8'h00)
                      && ((low_bits_c & (low_bits_c - 8'd1)) == 8'h00);
        an_glitch_c = !an_idle_c && !an_legal_c;
        an_idx_c    = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!an_s2_q[i]) an_idx_c = IDX_W'(i);
        end
    end

    // Per-digit visit FSM
    always_comb begin
        state_d     = state_q;
        lat_an_d    = lat_an_q;
        lat_seg_d   = lat_seg_q;
        lat_idx_d   = lat_idx_q;
        set_cnt_d   = set_cnt_q;
        do_sample_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (an_legal_c) begin
                    lat_an_d  = an_s2_q;
                    lat_seg_d = seg_s2_q;
                    lat_idx_d = an_idx_c;
                    set_cnt_d = '0;
                    state_d   = (SETTLE_CYCLES <= 1) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (an_idle_c) begin
                    state_d = S_IDLE;
                end else if (an_legal_c) begin
                    if (an_s2_q == lat_an_q && seg_s2_q == lat_seg_q) begin
                        set_cnt_d = set_cnt_q + SET_W'(1);
                        if (set_cnt_d == SET_LAST) state_d = S_SAMPLE;
                    end else begin
                        lat_an_d  = an_s2_q;
                        lat_seg_d = seg_s2_q;
                        lat_idx_d = an_idx_c;
                        set_cnt_d = '0;
                    end
                end
            end
            S_SAMPLE: begin
                do_sample_c = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (an_s2_q != lat_an_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (an_glitch_c) state_d = S_IDLE;
    end

    // Shadow frame, frame completion, timeout and published outputs
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        prev_d      = prev_q;
        prev_dp_d   = prev_dp_q;
        seen_d      = seen_q;
        have_prev_d = have_prev_q;
        done_d      = do_sample_c;
        to_cnt_d    = to_cnt_q;
        digits_d    = digits_q;
        dp_d        = dp_q;
        err_d       = err_q;
        fv_d        = 1'b0;
        tout_d      = 1'b0;
        glitch_d    = glitch_q;
        code_c      = seg_decode(lat_seg_q[6:0]);

        frame_has_f_c = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (shadow_q[4*i +: 4] == 4'hF) frame_has_f_c = 1'b1;
        end

        if (an_glitch_c && glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;

        if (done_q && (&seen_q)) begin
            if (have_prev_q && shadow_q == prev_q && shadow_dp_q == prev_dp_q) begin
                digits_d = shadow_q;
                dp_d     = shadow_dp_q;
                err_d    = frame_has_f_c;
                fv_d     = 1'b1;
            end
            prev_d      = shadow_q;
            prev_dp_d   = shadow_dp_q;
            have_prev_d = 1'b1;
            seen_d      = '0;
            to_cnt_d    = '0;
        end else if (seen_q != '0) begin
            if (to_cnt_q == TO_LAST) begin
                tout_d      = 1'b1;
                seen_d      = '0;
                have_prev_d = 1'b0;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        // A fresh sample survives a same-cycle timeout clear
        if (do_sample_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (IDX_W'(i) == lat_idx_q) begin
                    shadow_d[4*i +: 4] = code_c;
                    shadow_dp_d[i]     = ~lat_seg_q[7];
                    seen_d[i]          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
        if (!RESET_BTN) begin
            an_s1_q     <= 8'hFF;
            an_s2_q     <= 8'hFF;
            seg_s1_q    <= 8'hFF;
            seg_s2_q    <= 8'hFF;
            state_q     <= S_IDLE;
            lat_an_q    <= 8'hFF;
            lat_seg_q   <= 8'hFF;
            lat_idx_q   <= '0;
            set_cnt_q   <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            prev_q      <= '0;
            prev_dp_q   <= '0;
            seen_q      <= '0;
            have_prev_q <= 1'b0;
            done_q      <= 1'b0;
            to_cnt_q    <= '0;
            digits_q    <= '0;
            dp_q        <= '0;
            fv_q        <= 1'b0;
            err_q       <= 1'b0;
            tout_q      <= 1'b0;
            glitch_q    <= 8'h00;
        end else begin
            an_s1_q     <= an_s1_d;
            an_s2_q     <= an_s2_d;
            seg_s1_q    <= seg_s1_d;
            seg_s2_q    <= seg_s2_d;
            state_q     <= state_d;
            lat_an_q    <= lat_an_d;
            lat_seg_q   <= lat_seg_d;
            lat_idx_q   <= lat_idx_d;
            set_cnt_q   <= set_cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            prev_q      <= prev_d;
            prev_dp_q   <= prev_dp_d;
            seen_q      <= seen_d;
            have_prev_q <= have_prev_d;
            done_q      <= done_d;
            to_cnt_q    <= to_cnt_d;
            digits_q    <= digits_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            err_q       <= err_d;
            tout_q      <= tout_d;
            glitch_q    <= glitch_d;
        end
    end

    assign DIGITS       = digits_q;
    assign DP_OUT       = dp_q;
    assign FRAME_VALID  = fv_q;
    assign DIGIT_ERR    = err_q;
    assign SCAN_TIMEOUT = tout_q;
    assign GLITCH_CNT   = glitch_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans a 4-digit display pattern and checks the
// published frame, glitch counter, settle boundary, timeout and asynchronous reset.
module tb_seg_scan_decoder;

    logic        CLK100MHZ = 1'b0;
    logic        RESET_BTN;
    logic [7:0]  SevenSegment;
    logic [7:0]  SegmentDrivers;
    logic [15:0] DIGITS;
    logic [3:0]  DP_OUT;
    logic        FRAME_VALID;
    logic        DIGIT_ERR;
    logic        SCAN_TIMEOUT;
    logic [7:0]  GLITCH_CNT;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int fv_cnt = 0;
    int to_cnt = 0;
    int to_at  = 0;
    int fv0, to0, t0;

    seg_scan_decoder #(
        .NUM_DIGITS    (4),
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK100MHZ     (CLK100MHZ),
        .RESET_BTN     (RESET_BTN),
        .SevenSegment  (SevenSegment),
        .SegmentDrivers(SegmentDrivers),
        .DIGITS        (DIGITS),
        .DP_OUT        (DP_OUT),
        .FRAME_VALID   (FRAME_VALID),
        .DIGIT_ERR     (DIGIT_ERR),
        .SCAN_TIMEOUT  (SCAN_TIMEOUT),
        .GLITCH_CNT    (GLITCH_CNT)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    // Pulse monitors sample on the falling edge, mid-cycle
    always @(negedge CLK100MHZ) begin
        if (FRAME_VALID === 1'b1) fv_cnt <= fv_cnt + 1;
        if (SCAN_TIMEOUT === 1'b1) begin
            to_cnt <= to_cnt + 1;
            to_at  <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic show(input logic [7:0] an, input logic [7:0] seg, input int n);
        SegmentDrivers = an;
        SevenSegment   = seg;
        repeat (n) @(negedge CLK100MHZ);
    endtask

    // One pass over digits 0..3, optional blank gap after each digit, then an 8-cycle blank tail
    task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] s3, input int hold, input int gap);
        show(8'hFE, s0, hold); if (gap > 0) show(8'hFF, 8'hFF, gap);
        show(8'hFD, s1, hold); if (gap > 0) show(8'hFF, 8'hFF, gap);
        show(8'hFB, s2, hold); if (gap > 0) show(8'hFF, 8'hFF, gap);
        show(8'hF7, s3, hold);
        show(8'hFF, 8'hFF, 8);
    endtask

    task automatic do_reset();
        RESET_BTN = 1'b0;
        show(8'hFF, 8'hFF, 3);
        RESET_BTN = 1'b1;
        repeat (2) @(negedge CLK100MHZ);
    endtask

    initial begin
        RESET_BTN      = 1'b0;
        SevenSegment   = 8'hFF;
        SegmentDrivers = 8'hFF;
        repeat (2) @(negedge CLK100MHZ);
        chk("rst_digits", 32'(DIGITS), 32'h0);
        chk("rst_dp", 32'(DP_OUT), 32'h0);
        chk("rst_fv", 32'(FRAME_VALID), 32'h0);
        chk("rst_err", 32'(DIGIT_ERR), 32'h0);
        chk("rst_tout", 32'(SCAN_TIMEOUT), 32'h0);
        chk("rst_glitch", 32'(GLITCH_CNT), 32'h0);
        RESET_BTN = 1'b1;
        repeat (2) @(negedge CLK100MHZ);

        // Two identical scans of 0,1,2,3 publish once
        fv0 = fv_cnt;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        chk("t1_pass1_no_pulse", 32'(fv_cnt), 32'(fv0));
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        chk("t1_pulse", 32'(fv_cnt), 32'(fv0 + 1));
        chk("t1_digits", 32'(DIGITS), 32'h3210);
        chk("t1_dp", 32'(DP_OUT), 32'h0);
        chk("t1_err", 32'(DIGIT_ERR), 32'h0);

        // Differing second pass delays publication to the third pass
        do_reset();
        fv0 = fv_cnt;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        scan(8'hC0, 8'h92, 8'hA4, 8'hB0, 8, 0);
        chk("t2_pass2_no_pulse", 32'(fv_cnt), 32'(fv0));
        scan(8'hC0, 8'h92, 8'hA4, 8'hB0, 8, 0);
        chk("t2_pass3_pulse", 32'(fv_cnt), 32'(fv0 + 1));
        chk("t2_digits", 32'(DIGITS), 32'h3250);

        // Blank with DP lit -> E, unknown pattern 0x55 (DP lit) -> F
        do_reset();
        fv0 = fv_cnt;
        scan(8'hC0, 8'hF9, 8'h7F, 8'h55, 8, 0);
        scan(8'hC0, 8'hF9, 8'h7F, 8'h55, 8, 0);
        chk("t3_pulse", 32'(fv_cnt), 32'(fv0 + 1));
        chk("t3_digits", 32'(DIGITS), 32'hFE10);
        chk("t3_dp", 32'(DP_OUT), 32'hC);
        chk("t3_err", 32'(DIGIT_ERR), 32'h1);

        // Two-low anode pattern FC: 3 glitch cycles per burst, saturating
        do_reset();
        fv0 = fv_cnt;
        repeat (10) begin show(8'hFC, 8'hFF, 3); show(8'hFF, 8'hFF, 1); end
        show(8'hFF, 8'hFF, 4);
        chk("glitch_30", 32'(GLITCH_CNT), 32'd30);
        repeat (290) begin show(8'hFC, 8'hFF, 3); show(8'hFF, 8'hFF, 1); end
        show(8'hFF, 8'hFF, 4);
        chk("glitch_sat", 32'(GLITCH_CNT), 32'd255);
        chk("glitch_no_fv", 32'(fv_cnt), 32'(fv0));

        // Holding each digit 3 cycles never samples; 4 cycles does
        do_reset();
        fv0 = fv_cnt;
        to0 = to_cnt;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 3, 2);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 3, 2);
        show(8'hFF, 8'hFF, 120);
        chk("short_no_fv", 32'(fv_cnt), 32'(fv0));
        chk("short_no_tout", 32'(to_cnt), 32'(to0));
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4, 2);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4, 2);
        chk("settle4_fv", 32'(fv_cnt), 32'(fv0 + 1));
        chk("settle4_digits", 32'(DIGITS), 32'h3210);

        // Partial frame: sample lands 6 cycles after the drive, pulse 100 cycles later,
        // registered -> visible 107 cycles after the drive
        do_reset();
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        fv0 = fv_cnt;
        to0 = to_cnt;
        t0  = cyc;
        show(8'hFE, 8'hC0, 8);
        show(8'hFD, 8'hF9, 8);
        show(8'hFF, 8'hFF, 120);
        chk("tout_count", 32'(to_cnt), 32'(to0 + 1));
        chk("tout_latency", 32'(to_at - t0), 32'd107);
        chk("tout_no_fv", 32'(fv_cnt), 32'(fv0));
        chk("tout_digits_kept", 32'(DIGITS), 32'h3210);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        chk("tout_prev_cleared", 32'(fv_cnt), 32'(fv0));
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        chk("tout_recover_fv", 32'(fv_cnt), 32'(fv0 + 1));

        // Asynchronous reset in the middle of a pass
        do_reset();
        show(8'hFC, 8'hFF, 2);
        show(8'hFF, 8'hFF, 4);
        chk("pre_rst_glitch", 32'(GLITCH_CNT), 32'd2);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        chk("pre_rst_digits", 32'(DIGITS), 32'h3210);
        show(8'hFE, 8'hC0, 8);
        show(8'hFD, 8'hF9, 3);
        #2 RESET_BTN = 1'b0;
        #1;
        chk("arst_digits", 32'(DIGITS), 32'h0);
        chk("arst_dp", 32'(DP_OUT), 32'h0);
        chk("arst_fv", 32'(FRAME_VALID), 32'h0);
        chk("arst_err", 32'(DIGIT_ERR), 32'h0);
        chk("arst_tout", 32'(SCAN_TIMEOUT), 32'h0);
        chk("arst_glitch", 32'(GLITCH_CNT), 32'h0);
        SegmentDrivers = 8'hFF;
        SevenSegment   = 8'hFF;
        repeat (3) @(negedge CLK100MHZ);
        RESET_BTN = 1'b1;
        repeat (2) @(negedge CLK100MHZ);
        fv0 = fv_cnt;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        chk("post_rst_pass1_fv", 32'(fv_cnt), 32'(fv0));
        chk("post_rst_pass1_digits", 32'(DIGITS), 32'h0);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 8, 0);
        chk("post_rst_pass2_fv", 32'(fv_cnt), 32'(fv0 + 1));
        chk("post_rst_pass2_digits", 32'(DIGITS), 32'h3210);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
